// File: rtl/rst_seq_pkg.sv
// Shared state encoding and width helper for the staged reset sequencer.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2,
        ST_ASSERT  = 2'd3
    } rst_seq_state_e;

    function automatic int clog2_min1(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/rst_seq_timer.sv
// Loadable up-counter with a terminal-count flag; used for the sequencing
// delays and for the watchdog.
module rst_seq_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic [WIDTH-1:0] tc_val,
    output logic             tc
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == tc_val);

endmodule

// File: rtl/reset_sequencer.sv
// Releases NUM_STAGES resets in order and re-asserts them in reverse on a
// software request. Define RSTSEQ_WDOG_EN to add the RUN-state watchdog.
//
// state   | meaning
// HOLD    | all stages asserted, minimum pulse width
// RELEASE | releasing stage idx every STAGE_DELAY cycles
// RUN     | all stages released, soft reset requests accepted
// ASSERT  | re-asserting stage idx every STAGE_DELAY cycles
module reset_sequencer
    import rst_seq_pkg::*;
#(
    parameter int NUM_STAGES  = 3,
    parameter int STAGE_DELAY = 16,
    parameter int PULSE_MIN   = 4,
    parameter int WDOG_CYCLES = 1024
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  soft_rst_req,
    output logic                  soft_rst_ack,
    output logic [NUM_STAGES-1:0] rst_n_out,
    output logic                  seq_done,
    output logic                  busy
`ifdef RSTSEQ_WDOG_EN
    ,
    input  logic                  wdog_kick,
    output logic                  wdog_fired
`endif
);

    localparam int CNT_W = (clog2_min1(STAGE_DELAY) > clog2_min1(PULSE_MIN)) ?
                           clog2_min1(STAGE_DELAY) : clog2_min1(PULSE_MIN);
    localparam int IDX_W = clog2_min1(NUM_STAGES);

    localparam logic [CNT_W-1:0] HOLD_TC   = CNT_W'(PULSE_MIN - 1);
    localparam logic [CNT_W-1:0] STAGE_TC  = CNT_W'(STAGE_DELAY - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_STAGES - 1);
    localparam logic [IDX_W-1:0] FIRST_ASR = IDX_W'((NUM_STAGES > 1) ? NUM_STAGES - 2 : 0);

    if (NUM_STAGES < 1 || STAGE_DELAY < 1 || PULSE_MIN < 1 || WDOG_CYCLES < 1) begin : g_param_check
        $error("reset_sequencer: all parameters must be >= 1");
    end

    rst_seq_state_e        state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [NUM_STAGES-1:0] rst_n_out_q, rst_n_out_d;
    logic                  seq_done_q, seq_done_d;
    logic                  busy_q, busy_d;
    logic                  soft_rst_ack_q, soft_rst_ack_d;

    logic                  seq_tc;
    logic                  seq_load;
    logic [CNT_W-1:0]      seq_tc_val;
    logic                  req_trig;

    // The delay counter idles at zero in RUN so ASSERT always starts from a full delay.
    assign seq_tc_val = (state_q == ST_HOLD) ? HOLD_TC : STAGE_TC;
    assign seq_load   = (state_q == ST_RUN) || seq_tc;

    rst_seq_timer #(
        .WIDTH(CNT_W)
    ) u_seq_timer (
        .clock    (clock),
        .reset_n  (reset_n),
        .load     (seq_load),
        .load_val ({CNT_W{1'b0}}),
        .en       (1'b1),
        .tc_val   (seq_tc_val),
        .tc       (seq_tc)
    );

`ifdef RSTSEQ_WDOG_EN
    localparam int               WDOG_W  = clog2_min1(WDOG_CYCLES);
    localparam logic [WDOG_W-1:0] WDOG_TC = WDOG_W'(WDOG_CYCLES - 1);

    logic wdog_tc;
    logic wdog_timeout;
    logic wdog_fired_q, wdog_fired_d;

    rst_seq_timer #(
        .WIDTH(WDOG_W)
    ) u_wdog_timer (
        .clock    (clock),
        .reset_n  (reset_n),
        .load     (wdog_kick || (state_q != ST_RUN)),
        .load_val ({WDOG_W{1'b0}}),
        .en       (1'b1),
        .tc_val   (WDOG_TC),
        .tc       (wdog_tc)
    );

    assign wdog_timeout = (state_q == ST_RUN) && wdog_tc && !wdog_kick;
    assign wdog_fired_d = wdog_fired_q || wdog_timeout;
    assign req_trig     = soft_rst_req || wdog_timeout;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wdog_fired_q <= 1'b0;
        end else begin
            wdog_fired_q <= wdog_fired_d;
        end
    end

    assign wdog_fired = wdog_fired_q;
`else
    assign req_trig = soft_rst_req;
`endif

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        rst_n_out_d    = rst_n_out_q;
        seq_done_d     = seq_done_q;
        busy_d         = busy_q;
        soft_rst_ack_d = 1'b0;
        case (state_q)
            ST_HOLD: begin
                if (seq_tc) begin
                    idx_d   = '0;
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (seq_tc) begin
                    rst_n_out_d[idx_q] = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        seq_done_d = 1'b1;
                        busy_d     = 1'b0;
                        state_d    = ST_RUN;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            ST_RUN: begin
                if (req_trig) begin
                    rst_n_out_d[NUM_STAGES-1] = 1'b0;
                    seq_done_d                = 1'b0;
                    busy_d                    = 1'b1;
                    if (NUM_STAGES == 1) begin
                        soft_rst_ack_d = 1'b1;
                        state_d        = ST_HOLD;
                    end else begin
                        idx_d   = FIRST_ASR;
                        state_d = ST_ASSERT;
                    end
                end
            end
            ST_ASSERT: begin
                if (seq_tc) begin
                    rst_n_out_d[idx_q] = 1'b0;
                    if (idx_q == '0) begin
                        soft_rst_ack_d = 1'b1;
                        state_d        = ST_HOLD;
                    end else begin
                        idx_d = idx_q - IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_HOLD;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q        <= ST_HOLD;
            idx_q          <= '0;
            rst_n_out_q    <= '0;
            seq_done_q     <= 1'b0;
            busy_q         <= 1'b1;
            soft_rst_ack_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            rst_n_out_q    <= rst_n_out_d;
            seq_done_q     <= seq_done_d;
            busy_q         <= busy_d;
            soft_rst_ack_q <= soft_rst_ack_d;
        end
    end

    assign rst_n_out    = rst_n_out_q;
    assign seq_done     = seq_done_q;
    assign busy         = busy_q;
    assign soft_rst_ack = soft_rst_ack_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: directed scenarios plus randomized requests and
// resets checked against a timeline model. Define RSTSEQ_WDOG_EN for the watchdog.
module tb_reset_sequencer;

    localparam int NS = 3;
    localparam int SD = 16;
    localparam int PM = 4;
    localparam int WD = 8;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          soft_rst_req = 1'b0;
    logic          soft_rst_ack;
    logic          seq_done;
    logic          busy;
    logic [NS-1:0] rst_n_out;
    wire           fired_w;

`ifdef RSTSEQ_WDOG_EN
    logic wdog_kick = 1'b1;
    logic wdog_fired;
    assign fired_w = wdog_fired;
`else
    assign fired_w = 1'b0;
`endif

    int compared = 0;
    int mismatched = 0;

    always #5 clock = ~clock;

    reset_sequencer #(
        .NUM_STAGES  (NS),
        .STAGE_DELAY (SD),
        .PULSE_MIN   (PM),
        .WDOG_CYCLES (WD)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .soft_rst_req (soft_rst_req),
        .soft_rst_ack (soft_rst_ack),
        .rst_n_out    (rst_n_out),
        .seq_done     (seq_done),
        .busy         (busy)
`ifdef RSTSEQ_WDOG_EN
        ,
        .wdog_kick    (wdog_kick),
        .wdog_fired   (wdog_fired)
`endif
    );

    // Reference timeline: outputs derived from edges elapsed since the last
    // release start (reset or ack) or since the request edge.
    int            edge_n = 0;
    int            anchor = 0;
    int            wd_ref = 0;
    int            phase = 0;
    logic [NS-1:0] exp_rst = '0;
    logic          exp_done = 1'b0;
    logic          exp_ack = 1'b0;
    logic          exp_fired = 1'b0;

    function automatic logic [NS-1:0] low_mask(input int n);
        logic [NS-1:0] m = '0;
        for (int i = 0; i < NS; i++) begin
            if (i < n) m[i] = 1'b1;
        end
        return m;
    endfunction

    always @(posedge clock) begin : ref_model
        int   n;
        logic fire;
        edge_n  = edge_n + 1;
        exp_ack = 1'b0;
        fire    = 1'b0;
        if (!reset_n) begin
            phase     = 0;
            anchor    = edge_n;
            exp_rst   = '0;
            exp_done  = 1'b0;
            exp_fired = 1'b0;
        end else begin
            if (phase == 0) begin
                n = 0;
                for (int i = 0; i < NS; i++) begin
                    if (edge_n - anchor >= PM + (i + 1) * SD) n++;
                end
                exp_rst = low_mask(n);
                if (n == NS) begin
                    phase    = 1;
                    exp_done = 1'b1;
                    wd_ref   = edge_n;
                end
            end else if (phase == 1) begin
`ifdef RSTSEQ_WDOG_EN
                if (wdog_kick) wd_ref = edge_n;
                else if (edge_n - wd_ref >= WD) fire = 1'b1;
`endif
                if (soft_rst_req || fire) begin
                    phase    = 2;
                    anchor   = edge_n;
                    exp_done = 1'b0;
                    if (fire) exp_fired = 1'b1;
                end
            end
            if (phase == 2) begin
                n = 1 + (edge_n - anchor) / SD;
                if (n >= NS) begin
                    exp_rst = '0;
                    exp_ack = 1'b1;
                    phase   = 0;
                    anchor  = edge_n;
                end else begin
                    exp_rst = low_mask(NS - n);
                end
            end
        end
    end

    wire [NS+3:0] obs_vec = {rst_n_out, seq_done, busy, soft_rst_ack, fired_w};
    wire [NS+3:0] exp_vec = {exp_rst, exp_done, ~exp_done, exp_ack, exp_fired};

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (5) @(negedge clock);
        if (obs_vec !== {{NS{1'b0}}, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            mismatched++;
            $display("FAIL reset_state got=%b want=%b", obs_vec, {{NS{1'b0}}, 4'b0100});
        end
        compared++;
    endtask

    task automatic test_power_up();
        logic [NS-1:0] exp_c;
        logic          done_c;
        reset_n = 1'b1;
        for (int e = 1; e <= 56; e++) begin
            @(negedge clock);
            exp_c  = (e >= 52) ? 3'b111 : (e >= 36) ? 3'b011 : (e >= 20) ? 3'b001 : 3'b000;
            done_c = (e >= 52);
            if ({rst_n_out, seq_done, busy, soft_rst_ack} !== {exp_c, done_c, ~done_c, 1'b0}) begin
                mismatched++;
                $display("FAIL power_up edge=%0d got=%b want=%b", e,
                         {rst_n_out, seq_done, busy, soft_rst_ack}, {exp_c, done_c, ~done_c, 1'b0});
            end
            compared++;
        end
    endtask

    task automatic test_soft_reset();
        int ack_at = -1;
        int done_at = -1;
        soft_rst_req = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clock);
            if (obs_vec !== exp_vec) begin
                mismatched++;
                $display("FAIL soft_reset cyc=%0d got=%b want=%b", c, obs_vec, exp_vec);
            end
            compared++;
            if (c == 0 || c == 16) begin
                if (rst_n_out !== ((c == 0) ? 3'b011 : 3'b001)) begin
                    mismatched++;
                    $display("FAIL soft_reset_stage cyc=%0d got=%b", c, rst_n_out);
                end
                compared++;
            end
            if (soft_rst_ack && ack_at < 0) begin
                ack_at = c;
                soft_rst_req = 1'b0;
            end
            if (seq_done && ack_at >= 0 && done_at < 0) done_at = c;
        end
        if (ack_at != 32 || done_at != 84) begin
            mismatched++;
            $display("FAIL soft_reset_timing ack=%0d done=%0d want ack=32 done=84", ack_at, done_at);
        end
        compared++;
        soft_rst_req = 1'b0;
    endtask

    task automatic test_held_request();
        int acks = 0;
        int ack1 = -1;
        int ack2 = -1;
        soft_rst_req = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clock);
            if (obs_vec !== exp_vec) begin
                mismatched++;
                $display("FAIL held_request cyc=%0d got=%b want=%b", c, obs_vec, exp_vec);
            end
            compared++;
            if (soft_rst_ack) begin
                acks++;
                if (acks == 1) ack1 = c;
                if (acks == 2) begin
                    ack2 = c;
                    soft_rst_req = 1'b0;
                end
            end
        end
        if (acks != 2 || ack2 - ack1 != 85) begin
            mismatched++;
            $display("FAIL held_request_acks count=%0d gap=%0d want count=2 gap=85", acks, ack2 - ack1);
        end
        compared++;
        soft_rst_req = 1'b0;
    endtask

    task automatic test_mid_reset();
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        for (int e = 1; e <= 25; e++) begin
            @(negedge clock);
            if (obs_vec !== exp_vec) begin
                mismatched++;
                $display("FAIL mid_reset_pre edge=%0d got=%b want=%b", e, obs_vec, exp_vec);
            end
            compared++;
        end
        if (rst_n_out !== 3'b001) begin
            mismatched++;
            $display("FAIL mid_reset_setup got=%b want=001", rst_n_out);
        end
        compared++;
        reset_n = 1'b0;
        @(negedge clock);
        if ({rst_n_out, busy, seq_done} !== 5'b00010) begin
            mismatched++;
            $display("FAIL mid_reset_forced got=%b want=00010", {rst_n_out, busy, seq_done});
        end
        compared++;
        reset_n = 1'b1;
        for (int e = 1; e <= 56; e++) begin
            @(negedge clock);
            if (obs_vec !== exp_vec) begin
                mismatched++;
                $display("FAIL mid_reset_post edge=%0d got=%b want=%b", e, obs_vec, exp_vec);
            end
            compared++;
            if (e == 19 || e == 20) begin
                if (rst_n_out[0] !== (e == 20)) begin
                    mismatched++;
                    $display("FAIL mid_reset_restart edge=%0d got=%b", e, rst_n_out);
                end
                compared++;
            end
        end
    endtask

    task automatic test_ignored_request();
        int acks = 0;
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        soft_rst_req = 1'b1;
        for (int e = 1; e <= 60; e++) begin
            @(negedge clock);
            if (e == 3) soft_rst_req = 1'b0;
            if (obs_vec !== exp_vec) begin
                mismatched++;
                $display("FAIL ignored_request edge=%0d got=%b want=%b", e, obs_vec, exp_vec);
            end
            compared++;
            if (soft_rst_ack) acks++;
        end
        if (acks != 0 || rst_n_out !== 3'b111 || seq_done !== 1'b1) begin
            mismatched++;
            $display("FAIL ignored_request_end acks=%0d rst=%b done=%b want 0/111/1", acks, rst_n_out, seq_done);
        end
        compared++;
    endtask

`ifdef RSTSEQ_WDOG_EN
    task automatic test_watchdog();
        reset_n = 1'b0;
        wdog_kick = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        for (int e = 1; e <= 260; e++) begin
            @(negedge clock);
            if (obs_vec !== exp_vec) begin
                mismatched++;
                $display("FAIL watchdog edge=%0d got=%b want=%b", e, obs_vec, exp_vec);
            end
            compared++;
            if (e == 59 || e == 60) begin
                if ({rst_n_out, wdog_fired} !== ((e == 59) ? 4'b1110 : 4'b0111)) begin
                    mismatched++;
                    $display("FAIL watchdog_fire edge=%0d got=%b", e, {rst_n_out, wdog_fired});
                end
                compared++;
            end
            if (e > 150 && (seq_done !== 1'b1 || wdog_fired !== 1'b1)) begin
                mismatched++;
                $display("FAIL watchdog_kicked edge=%0d done=%b fired=%b want 1/1", e, seq_done, wdog_fired);
            end
            if (e > 150) compared++;
            wdog_kick = (e > 60) && (e % 4 == 0);
        end
        reset_n = 1'b0;
        @(negedge clock);
        if (wdog_fired !== 1'b0) begin
            mismatched++;
            $display("FAIL watchdog_clear got=%b want=0", wdog_fired);
        end
        compared++;
        reset_n = 1'b1;
    endtask
`endif

    task automatic test_random();
        int rst_len = 0;
        int acks = 0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clock);
            if (obs_vec !== exp_vec) begin
                mismatched++;
                $display("FAIL random cyc=%0d got=%b want=%b", c, obs_vec, exp_vec);
            end
            compared++;
            if (soft_rst_ack) acks++;
            if (!reset_n) begin
                rst_len--;
                if (rst_len <= 0) reset_n = 1'b1;
            end else if ($urandom_range(0, 399) == 0) begin
                reset_n = 1'b0;
                rst_len = int'($urandom_range(1, 3));
            end
            if (soft_rst_req && soft_rst_ack) soft_rst_req = 1'b0;
            else if (!soft_rst_req && $urandom_range(0, 29) == 0) soft_rst_req = 1'b1;
`ifdef RSTSEQ_WDOG_EN
            wdog_kick = ($urandom_range(0, 5) != 0);
`endif
        end
        if (acks == 0) begin
            mismatched++;
            $display("FAIL random_acks got=0 want>0");
        end
        compared++;
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_soft_reset();
        test_held_request();
        test_mid_reset();
        test_ignored_request();
`ifdef RSTSEQ_WDOG_EN
        test_watchdog();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
